alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Multi-cycle controller that sequences the shared ALU for R-type instructions. Accepts one 32-bit instruction per valid/ready handshake and reads rs/rt from the register file (synchronous read ports). It then drives ALU operands, funct and shamt, captures the result and writes it back to rd. It sits between instruction fetch/issue and the register file + ALU pair, and flags unsupported encodings.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept (high only in IDLE)
instr  in  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
rf_raddr1  out  5  register-file read address, port 1 (rs)
rf_raddr2  out  5  register-file read address, port 2 (rt)
rf_rdata1  in  32  read data, valid one cycle after rf_raddr1
rf_rdata2  in  32  read data, valid one cycle after rf_raddr2
alu_rs_data  out  32  ALU operand A
alu_rt_data  out  32  ALU operand B
alu_funct  out  6  ALU operation select
alu_shamt  out  5  ALU shift amount
alu_result  in  32  ALU combinational result
rf_we  out  1  register-file write enable
rf_waddr  out  5  write address (rd)
rf_wdata  out  32  write data
done  out  1  one-cycle pulse: instruction retired
illegal  out  1  one-cycle pulse: instruction rejected
busy  out  1  high in any state except IDLE
retired_count  out  CNT_W  count of retired (non-illegal) instructions

Behaviour:
- Reset (async, rst=1): state=IDLE; instr_ready=1; rf_we=0, done=0, illegal=0, busy=0; retired_count=0; all address, data, funct and shamt outputs=0.
- Supported funct codes: ADDU 6'b001001, SUBU 6'b001010, SLL 6'b100001, SLLV 6'b110101. Legal means opcode==0 and funct in this set.
- FSM states: IDLE, READ, EXEC, WB, ERR.
- IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr. Legal -> READ; otherwise -> ERR. The instruction is consumed either way.
- READ: rf_raddr1=rs, rf_raddr2=rt (from latched instr) -> EXEC.
- EXEC: alu_rs_data=rf_rdata1, alu_rt_data=rf_rdata2, alu_funct and alu_shamt from the latched instr. Capture alu_result into the result register at the end of the cycle -> WB.
- WB: rf_waddr=rd, rf_wdata=captured result, done=1. rf_we=1 only if rd!=0; rd==0 suppresses the write but still retires. retired_count increments, wrapping from all-ones to 0 -> IDLE.
- ERR: illegal=1 for one cycle; no register-file write; retired_count unchanged -> IDLE.
- Latency: handshake accepted at edge T; READ during cycle T+1, EXEC T+2, WB T+3 (rf_we high). Throughput is one instruction per 4 cycles. ERR costs 2 cycles including acceptance.
- instr_valid is ignored outside IDLE. instr_ready is a pure function of state; there is no combinational path from instr_valid to any output.
- rf_raddr*, alu_* and rf_waddr/rf_wdata hold their last values outside their active state. rf_we, done and illegal are 0 outside WB/ERR.
- Shift semantics are the ALU's. The sequencer passes rs data as the shifted operand and rt data unmodified, with no width truncation.
- Reset mid-operation: immediate return to IDLE; a pending write is dropped and no done pulse is generated.

Test Plan:
- ADDU: r1=5, r2=7, instr rs=1 rt=2 rd=3 funct=001001 -> rf_we in cycle T+3, waddr=3, wdata=12, done=1, retired_count=1.
- SLL/SLLV: r4=32'h1, SLL shamt=4 rd=5 -> wdata=32'h10. SLLV with r6=3 -> wdata=32'h8. SUBU 3-5 -> 32'hFFFFFFFE.
- rd=0 with ADDU -> rf_we stays 0, done=1, retired_count increments.
- Illegal: opcode=6'h23, then funct=6'h00 -> illegal pulses one cycle each, rf_we never asserts, retired_count unchanged.
- Back-to-back with instr_valid held high for 3 instructions -> accepted only in IDLE (every 4 cycles), each written once, in order.
- rst asserted during EXEC -> rf_we and done never assert, outputs at reset values. With CNT_W=2, 5 retirements -> retired_count=1 (wrap).

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle controller that runs one R-type instruction at a time through a
// shared ALU: accept -> READ (register-file address) -> EXEC (ALU operands,
// result captured) -> WB (write rd, pulse done). Unsupported encodings take a
// short ERR detour that pulses illegal and writes nothing.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   instr_valid/instr_ready/instr instruction handshake (ready only in IDLE)
//   rf_raddr1/2, rf_rdata1/2      register-file read ports (data one cycle late)
//   alu_rs_data/alu_rt_data       ALU operands
//   alu_funct/alu_shamt           ALU operation select and shift amount
//   alu_result                    ALU combinational result
//   rf_we/rf_waddr/rf_wdata       register-file write port
//   done/illegal                  one-cycle retire / reject pulses
//   busy                          high in any state other than IDLE
//   retired_count                 retired-instruction counter, wraps
module alu_op_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    input  logic [31:0]      rf_rdata1,
    input  logic [31:0]      rf_rdata2,
    output logic [31:0]      alu_rs_data,
    output logic [31:0]      alu_rt_data,
    output logic [5:0]       alu_funct,
    output logic [4:0]       alu_shamt,
    input  logic [31:0]      alu_result,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             done,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [5:0] FN_ADDU = 6'b001001;
    localparam logic [5:0] FN_SUBU = 6'b001010;
    localparam logic [5:0] FN_SLL  = 6'b100001;
    localparam logic [5:0] FN_SLLV = 6'b110101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    // Latched fields of the accepted instruction
    logic [4:0]       rd_q, rd_d;
    logic [4:0]       lat_shamt_q, lat_shamt_d;
    logic [5:0]       lat_funct_q, lat_funct_d;

    // Output-holding registers
    logic [4:0]       raddr1_q, raddr1_d;
    logic [4:0]       raddr2_q, raddr2_d;
    logic [5:0]       funct_q, funct_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;   // doubles as the ALU result register
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic legal;

    assign accept = instr_valid && (state_q == S_IDLE);

    always_comb begin
        legal = 1'b0;
        if (instr[31:26] == 6'd0) begin
            case (instr[5:0])
                FN_ADDU, FN_SUBU, FN_SLL, FN_SLLV: legal = 1'b1;
                default:                          legal = 1'b0;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_q        <= '0;
            lat_shamt_q <= '0;
            lat_funct_q <= '0;
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            funct_q     <= '0;
            shamt_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            lat_shamt_q <= lat_shamt_d;
            lat_funct_q <= lat_funct_d;
            raddr1_q    <= raddr1_d;
            raddr2_q    <= raddr2_d;
            funct_q     <= funct_d;
            shamt_q     <= shamt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = legal ? S_READ : S_ERR;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; everything holds unless its stage is active
    always_comb begin
        rd_d        = rd_q;
        lat_shamt_d = lat_shamt_q;
        lat_funct_d = lat_funct_q;
        raddr1_d    = raddr1_q;
        raddr2_d    = raddr2_q;
        funct_d     = funct_q;
        shamt_d     = shamt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                // Read addresses are loaded at acceptance so they are already
                // on the port throughout READ; rejected encodings leave them.
                if (accept && legal) begin
                    raddr1_d    = instr[25:21];
                    raddr2_d    = instr[20:16];
                    rd_d        = instr[15:11];
                    lat_shamt_d = instr[10:6];
                    lat_funct_d = instr[5:0];
                end
            end
            S_READ: begin
                funct_d = lat_funct_q;
                shamt_d = lat_shamt_q;
            end
            S_EXEC: begin
                alu_a_d = rf_rdata1;
                alu_b_d = rf_rdata2;
                waddr_d = rd_q;
                wdata_d = alu_result;
                // Counter is updated entering WB so it reads back together
                // with done; a reset in EXEC therefore never counts.
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_WB);
        illegal     = (state_q == S_ERR);
        rf_we       = (state_q == S_WB) && (waddr_q != 5'd0);
        // Operands come straight from the register file during EXEC and hold
        // the captured copy afterwards.
        alu_rs_data = (state_q == S_EXEC) ? rf_rdata1 : alu_a_q;
        alu_rt_data = (state_q == S_EXEC) ? rf_rdata2 : alu_b_q;
    end

    assign rf_raddr1     = raddr1_q;
    assign rf_raddr2     = raddr2_q;
    assign alu_funct     = funct_q;
    assign alu_shamt     = shamt_q;
    assign rf_waddr      = waddr_q;
    assign rf_wdata      = wdata_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam logic [5:0] FN_ADDU = 6'b001001;
    localparam logic [5:0] FN_SUBU = 6'b001010;
    localparam logic [5:0] FN_SLL  = 6'b100001;
    localparam logic [5:0] FN_SLLV = 6'b110101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
    logic [31:0] alu_rs_data, alu_rt_data, alu_result, rf_wdata;
    logic [5:0]  alu_funct;
    logic [4:0]  alu_shamt;
    logic        rf_we, done, illegal, busy;
    logic [15:0] retired_count;

    // Second instance with a 2-bit counter for the wrap check
    logic        c2_ready, c2_we, c2_done, c2_illegal, c2_busy;
    logic [4:0]  c2_raddr1, c2_raddr2, c2_waddr, c2_shamt;
    logic [31:0] c2_rs, c2_rt, c2_wdata;
    logic [5:0]  c2_funct;
    logic [1:0]  c2_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] regs [32];
    logic [36:0] wq [$];
    int          acc_t [$];
    int          cyc = 0, we_cnt = 0, done_cnt = 0, ill_cnt = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_rs_data(alu_rs_data), .alu_rt_data(alu_rt_data),
        .alu_funct(alu_funct), .alu_shamt(alu_shamt), .alu_result(alu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .illegal(illegal), .busy(busy), .retired_count(retired_count)
    );

    alu_op_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(c2_ready),
        .instr(instr), .rf_raddr1(c2_raddr1), .rf_raddr2(c2_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_rs_data(c2_rs), .alu_rt_data(c2_rt),
        .alu_funct(c2_funct), .alu_shamt(c2_shamt), .alu_result(alu_result),
        .rf_we(c2_we), .rf_waddr(c2_waddr), .rf_wdata(c2_wdata),
        .done(c2_done), .illegal(c2_illegal), .busy(c2_busy), .retired_count(c2_count)
    );

    // Register file: synchronous read; contents preloaded by the stimulus
    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_raddr1];
        rf_rdata2 <= regs[rf_raddr2];
    end

    // ALU: rs is the shifted operand
    always_comb begin
        case (alu_funct)
            FN_ADDU: alu_result = alu_rs_data + alu_rt_data;
            FN_SUBU: alu_result = alu_rs_data - alu_rt_data;
            FN_SLL:  alu_result = alu_rs_data << alu_shamt;
            FN_SLLV: alu_result = alu_rs_data << alu_rt_data[4:0];
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_we) begin
            wq.push_back({rf_waddr, rf_wdata});
            we_cnt <= we_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (illegal) ill_cnt <= ill_cnt + 1;
        if (instr_valid && instr_ready) acc_t.push_back(cyc);
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // Offer one instruction, accepted at the next rising edge (DUT is idle)
    task automatic send(input logic [31:0] ins);
        @(negedge clk);
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    // Send a legal instruction and stop mid-WB
    task automatic do_op(input logic [31:0] ins);
        send(ins);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", instr_ready); end
        n_checks++; if ({busy, rf_we, done, illegal} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {busy, rf_we, done, illegal}); end
        n_checks++; if (retired_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", retired_count); end
        n_checks++; if ({rf_raddr1, rf_raddr2, rf_waddr, alu_funct, alu_shamt} !== 26'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", {rf_raddr1, rf_raddr2, rf_waddr, alu_funct, alu_shamt}); end
        n_checks++; if ({rf_wdata, alu_rs_data, alu_rt_data} !== 96'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {rf_wdata, alu_rs_data, alu_rt_data}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_addu;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        send(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADDU));
        @(negedge clk);  // READ
        n_checks++; if ({rf_raddr1, rf_raddr2} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL addu_raddr got %h exp %h", {rf_raddr1, rf_raddr2}, {5'd1, 5'd2}); end
        n_checks++; if ({busy, instr_ready} !== 2'b10) begin n_fail++; $display("FAIL addu_busy got %b exp 10", {busy, instr_ready}); end
        @(negedge clk);  // EXEC
        n_checks++; if ({alu_rs_data, alu_rt_data} !== {32'd5, 32'd7}) begin n_fail++; $display("FAIL addu_operands got %h exp %h", {alu_rs_data, alu_rt_data}, {32'd5, 32'd7}); end
        n_checks++; if (alu_funct !== FN_ADDU || rf_we !== 1'b0) begin n_fail++; $display("FAIL addu_exec got funct %b we %b exp %b 0", alu_funct, rf_we, FN_ADDU); end
        @(negedge clk);  // WB
        n_checks++; if ({rf_we, done} !== 2'b11) begin n_fail++; $display("FAIL addu_we_done got %b exp 11", {rf_we, done}); end
        n_checks++; if (rf_waddr !== 5'd3 || rf_wdata !== 32'd12) begin n_fail++; $display("FAIL addu_write got %0d/%h exp 3/0000000c", rf_waddr, rf_wdata); end
        n_checks++; if (retired_count !== 16'd1) begin n_fail++; $display("FAIL addu_count got %0d exp 1", retired_count); end
        @(negedge clk);  // IDLE
        n_checks++; if ({rf_we, done, instr_ready} !== 3'b001) begin n_fail++; $display("FAIL addu_idle got %b exp 001", {rf_we, done, instr_ready}); end
        n_checks++; if (rf_wdata !== 32'd12) begin n_fail++; $display("FAIL addu_hold got %h exp 0000000c", rf_wdata); end
    endtask

    task automatic test_shifts;
        regs[4]  = 32'h1;
        regs[6]  = 32'd3;
        regs[10] = 32'd3;
        regs[11] = 32'd5;
        do_op(enc(6'd0, 5'd4, 5'd0, 5'd5, 5'd4, FN_SLL));
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h10) begin n_fail++; $display("FAIL sll got we %b %0d/%h exp 1 5/00000010", rf_we, rf_waddr, rf_wdata); end
        n_checks++; if (alu_shamt !== 5'd4) begin n_fail++; $display("FAIL sll_shamt got %0d exp 4", alu_shamt); end
        @(negedge clk);
        do_op(enc(6'd0, 5'd4, 5'd6, 5'd7, 5'd0, FN_SLLV));
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h8) begin n_fail++; $display("FAIL sllv got we %b %0d/%h exp 1 7/00000008", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk);
        do_op(enc(6'd0, 5'd10, 5'd11, 5'd12, 5'd0, FN_SUBU));
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL subu got we %b %0d/%h exp 1 12/fffffffe", rf_we, rf_waddr, rf_wdata); end
        n_checks++; if (retired_count !== 16'd4) begin n_fail++; $display("FAIL shifts_count got %0d exp 4", retired_count); end
        @(negedge clk);
    endtask

    task automatic test_rd_zero;
        int we0;
        we0 = we_cnt;
        do_op(enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, FN_ADDU));
        n_checks++; if ({rf_we, done} !== 2'b01) begin n_fail++; $display("FAIL rd0_we_done got %b exp 01", {rf_we, done}); end
        n_checks++; if (retired_count !== 16'd5) begin n_fail++; $display("FAIL rd0_count got %0d exp 5", retired_count); end
        @(negedge clk);
        n_checks++; if (we_cnt !== we0) begin n_fail++; $display("FAIL rd0_writes got %0d exp %0d", we_cnt, we0); end
    endtask

    task automatic test_illegal;
        int we0, il0;
        we0 = we_cnt;
        il0 = ill_cnt;
        send(enc(6'h23, 5'd9, 5'd9, 5'd3, 5'd0, FN_ADDU));
        @(negedge clk);  // ERR
        n_checks++; if ({illegal, busy, rf_we, done} !== 4'b1100) begin n_fail++; $display("FAIL ill_op_err got %b exp 1100", {illegal, busy, rf_we, done}); end
        @(negedge clk);  // back in IDLE
        n_checks++; if ({illegal, instr_ready} !== 2'b01) begin n_fail++; $display("FAIL ill_op_idle got %b exp 01", {illegal, instr_ready}); end
        send(enc(6'd0, 5'd9, 5'd9, 5'd3, 5'd0, 6'h00));
        @(negedge clk);
        n_checks++; if ({illegal, rf_we, done} !== 3'b100) begin n_fail++; $display("FAIL ill_fn_err got %b exp 100", {illegal, rf_we, done}); end
        @(negedge clk);
        n_checks++; if (ill_cnt - il0 !== 2 || we_cnt !== we0) begin n_fail++; $display("FAIL ill_pulses got ill %0d we %0d exp 2 0", ill_cnt - il0, we_cnt - we0); end
        n_checks++; if (retired_count !== 16'd5) begin n_fail++; $display("FAIL ill_count got %0d exp 5", retired_count); end
        n_checks++; if (rf_raddr1 !== 5'd1) begin n_fail++; $display("FAIL ill_raddr_hold got %0d exp 1", rf_raddr1); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] prog [3];
        logic [36:0] exp_w [3];
        int i, a0;
        prog[0] = enc(6'd0, 5'd1, 5'd2, 5'd13, 5'd0, FN_ADDU);  // 5+7
        prog[1] = enc(6'd0, 5'd2, 5'd1, 5'd14, 5'd0, FN_SUBU);  // 7-5
        prog[2] = enc(6'd0, 5'd4, 5'd0, 5'd15, 5'd3, FN_SLL);   // 1<<3
        exp_w[0] = {5'd13, 32'd12};
        exp_w[1] = {5'd14, 32'd2};
        exp_w[2] = {5'd15, 32'd8};
        wq.delete();
        a0 = acc_t.size();
        i = 0;
        for (int c = 0; c < 40 && i < 3; c++) begin
            @(negedge clk);
            if (instr_ready) begin
                instr = prog[i];
                instr_valid = 1'b1;
                i++;
            end
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (acc_t.size() - a0 !== 3) begin n_fail++; $display("FAIL b2b_accepts got %0d exp 3", acc_t.size() - a0); end
        if (acc_t.size() - a0 == 3) begin
            n_checks++; if (acc_t[a0+1] - acc_t[a0] !== 4 || acc_t[a0+2] - acc_t[a0+1] !== 4) begin n_fail++; $display("FAIL b2b_spacing got %0d %0d exp 4 4", acc_t[a0+1] - acc_t[a0], acc_t[a0+2] - acc_t[a0+1]); end
        end
        n_checks++; if (wq.size() !== 3) begin n_fail++; $display("FAIL b2b_writes got %0d exp 3", wq.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < wq.size()) begin
                n_checks++; if (wq[k] !== exp_w[k]) begin n_fail++; $display("FAIL b2b_order%0d got %h exp %h", k, wq[k], exp_w[k]); end
            end
        end
        n_checks++; if (retired_count !== 16'd8) begin n_fail++; $display("FAIL b2b_count got %0d exp 8", retired_count); end
    endtask

    task automatic test_reset_mid;
        int we0, d0;
        we0 = we_cnt;
        d0 = done_cnt;
        send(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADDU));
        @(negedge clk);  // READ
        @(negedge clk);  // EXEC
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if ({instr_ready, busy, rf_we, done, illegal} !== 5'b10000) begin n_fail++; $display("FAIL mid_flags got %b exp 10000", {instr_ready, busy, rf_we, done, illegal}); end
        n_checks++; if (retired_count !== 16'd0 || {rf_raddr1, rf_waddr, alu_funct} !== 16'd0) begin n_fail++; $display("FAIL mid_regs got cnt %0d %h exp 0 0", retired_count, {rf_raddr1, rf_waddr, alu_funct}); end
        n_checks++; if ({rf_wdata, alu_rs_data} !== 64'd0) begin n_fail++; $display("FAIL mid_data got %h exp 0", {rf_wdata, alu_rs_data}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (we_cnt !== we0 || done_cnt !== d0) begin n_fail++; $display("FAIL mid_dropped got we %0d done %0d exp 0 0", we_cnt - we0, done_cnt - d0); end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 5; k++) begin
            do_op(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADDU));
            @(negedge clk);
        end
        n_checks++; if (c2_count !== 2'd1) begin n_fail++; $display("FAIL wrap_cnt2 got %0d exp 1", c2_count); end
        n_checks++; if (retired_count !== 16'd5) begin n_fail++; $display("FAIL wrap_cnt16 got %0d exp 5", retired_count); end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = '0;
        fork
            begin
                test_reset();
                test_addu();
                test_shifts();
                test_rd_zero();
                test_illegal();
                test_back_to_back();
                test_reset_mid();
                test_wrap();
            end
            begin
                #50000;
                n_checks++;
                n_fail++;
                $display("FAIL timeout got running exp finished");
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
